// File: rtl/spec_seq_checker.sv
// Enum sequence checker: accepts code beats that must follow 0,1,..,NUM_CODES-1 (wrapping),
// counts clean sequences and latches the first mismatch. Optional trace prints under SPEC_SEQ_TRACE_EN.
//
// state | meaning
// IDLE  | waiting for first beat of a sequence, expect_code = 0
// CHECK | mid-sequence, each beat compared against expect_code
// DONE  | clean sequence closed; seq_done high, counters settle, back to IDLE
// ERROR | mismatch latched; holds until clr
module spec_seq_checker #(
  parameter int NUM_CODES = 3,
  parameter int CODE_W    = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_last,
  input  logic              clr,
  output logic [CODE_W-1:0] expect_code,
  output logic              seq_done,
  output logic              err,
  output logic [CODE_W-1:0] err_code,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE, ERROR} state_t;

  localparam logic [CODE_W:0]   NUM_CODES_W = (CODE_W+1)'(NUM_CODES);
  localparam logic [CODE_W-1:0] LAST_CODE   = CODE_W'(NUM_CODES - 1);

  state_t             state, state_nxt;
  logic [CODE_W-1:0]  expect_nxt, err_code_nxt, next_code;
  logic [CNT_W-1:0]   pass_nxt, beat_nxt, beat_inc, pass_inc;
  logic               err_nxt, accept, mismatch;

  // in_ready depends on state only, never on in_valid
  assign in_ready = (state == IDLE) || (state == CHECK);
  assign seq_done = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign mismatch = ({1'b0, in_code} >= NUM_CODES_W) || (in_code != expect_code);

  assign next_code = (expect_code == LAST_CODE) ? '0 : expect_code + CODE_W'(1);
  assign beat_inc  = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_W'(1);
  assign pass_inc  = (pass_cnt == '1) ? pass_cnt : pass_cnt + CNT_W'(1);

  always_comb begin
    state_nxt    = state;
    expect_nxt   = expect_code;
    err_nxt      = err;
    err_code_nxt = err_code;
    pass_nxt     = pass_cnt;
    beat_nxt     = beat_cnt;
    case (state)
      IDLE, CHECK: begin
        if (accept) begin
          // mismatch wins over in_last on the same beat
          if (mismatch) begin
            state_nxt    = ERROR;
            err_nxt      = 1'b1;
            err_code_nxt = in_code;
          end else begin
            expect_nxt = next_code;
            beat_nxt   = beat_inc;
            state_nxt  = in_last ? DONE : CHECK;
          end
        end
      end
      DONE: begin
        pass_nxt   = pass_inc;
        beat_nxt   = '0;
        expect_nxt = '0;
        state_nxt  = IDLE;
      end
      ERROR: begin
        if (clr) begin
          err_nxt      = 1'b0;
          err_code_nxt = '0;
          beat_nxt     = '0;
          expect_nxt   = '0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      expect_code <= '0;
      err         <= 1'b0;
      err_code    <= '0;
      pass_cnt    <= '0;
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      expect_code <= expect_nxt;
      err         <= err_nxt;
      err_code    <= err_code_nxt;
      pass_cnt    <= pass_nxt;
      beat_cnt    <= beat_nxt;
    end
  end

`ifdef SPEC_SEQ_TRACE_EN
  function automatic string code_name(input logic [CODE_W-1:0] c);
    if ({1'b0, c} >= NUM_CODES_W) return "illegal";
    case (c)
      CODE_W'(0): return "industry";
      CODE_W'(1): return "medical";
      CODE_W'(2): return "education";
      default:    return "illegal";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && accept) $display("state=%s", code_name(in_code));
    if (rst_n && err_nxt && !err) $display("spe=%s", code_name(in_code));
  end
`endif

endmodule

// File: tb/tb_spec_seq_checker.sv
// Directed bench for spec_seq_checker: hand-computed expectations checked with immediate assertions.
module tb_spec_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_code = 2'd0;
  logic       in_last = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] expect_code;
  logic       seq_done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] pass_cnt;
  logic [7:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  spec_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_last(in_last), .clr(clr), .expect_code(expect_code),
    .seq_done(seq_done), .err(err), .err_code(err_code),
    .pass_cnt(pass_cnt), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code, input logic last);
    in_valid = 1'b1;
    in_code  = code;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_pass", pass_cnt, 0);
    chk("rst_beat", beat_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_expect", expect_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_done", seq_done, 0);

    // 0,1,2 with last on 2
    send(2'd0, 1'b0);
    chk("s1_expect1", expect_code, 1);
    chk("s1_beat1", beat_cnt, 1);
    send(2'd1, 1'b0);
    chk("s1_expect2", expect_code, 2);
    send(2'd2, 1'b1);
    chk("s1_done", seq_done, 1);
    chk("s1_ready_low", in_ready, 0);
    chk("s1_beat3", beat_cnt, 3);
    tick();
    chk("s1_done_off", seq_done, 0);
    chk("s1_pass", pass_cnt, 1);
    chk("s1_expect0", expect_code, 0);
    chk("s1_beat0", beat_cnt, 0);
    chk("s1_ready", in_ready, 1);

    // wrap: 0,1,2,0,1 with last on 1
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    chk("s2_wrap_expect", expect_code, 0);
    send(2'd0, 1'b0);
    send(2'd1, 1'b1);
    chk("s2_done", seq_done, 1);
    chk("s2_beat5", beat_cnt, 5);
    tick();
    chk("s2_pass", pass_cnt, 2);
    chk("s2_beat0", beat_cnt, 0);
    chk("s2_expect0", expect_code, 0);

    // 0,2 mismatch, then clr
    send(2'd0, 1'b0);
    send(2'd2, 1'b0);
    chk("s3_err", err, 1);
    chk("s3_err_code", err_code, 2);
    chk("s3_ready", in_ready, 0);
    chk("s3_beat", beat_cnt, 1);
    send(2'd1, 1'b1);
    chk("s3_hold_beat", beat_cnt, 1);
    chk("s3_hold_err", err, 1);
    chk("s3_no_done", seq_done, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s3_clr_err", err, 0);
    chk("s3_clr_code", err_code, 0);
    chk("s3_clr_ready", in_ready, 1);
    chk("s3_clr_beat", beat_cnt, 0);
    chk("s3_pass_kept", pass_cnt, 2);

    // clr outside ERROR is ignored
    send(2'd0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s3b_clr_ign_beat", beat_cnt, 1);
    chk("s3b_clr_ign_expect", expect_code, 1);
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    chk("s3b_done", seq_done, 1);
    tick();
    chk("s3b_pass", pass_cnt, 3);

    // illegal code 3 as first beat with last
    send(2'd3, 1'b1);
    chk("s4_err", err, 1);
    chk("s4_err_code", err_code, 3);
    chk("s4_no_done", seq_done, 0);
    tick();
    chk("s4_no_done2", seq_done, 0);
    chk("s4_pass", pass_cnt, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // legal but out-of-order code with last: mismatch beats in_last
    send(2'd1, 1'b1);
    chk("s4b_err", err, 1);
    chk("s4b_err_code", err_code, 1);
    chk("s4b_no_done", seq_done, 0);
    chk("s4b_beat", beat_cnt, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s4b_pass", pass_cnt, 3);

    // reset mid-sequence
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_pass", pass_cnt, 0);
    chk("s5_rst_beat", beat_cnt, 0);
    chk("s5_rst_expect", expect_code, 0);
    chk("s5_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("s5_ready", in_ready, 1);
    send(2'd0, 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    chk("s5_done", seq_done, 1);
    tick();
    chk("s5_pass", pass_cnt, 1);

    // beat_cnt saturation over a long sequence
    for (int i = 0; i < 260; i++) send(2'(i % 3), 1'b0);
    chk("s6_beat_sat", beat_cnt, 255);
    chk("s6_expect", expect_code, 2);
    chk("s6_err", err, 0);
    send(2'd2, 1'b1);
    chk("s6_done", seq_done, 1);
    chk("s6_beat_hold", beat_cnt, 255);
    tick();
    chk("s6_pass", pass_cnt, 2);
    chk("s6_beat0", beat_cnt, 0);

    // pass_cnt saturation
    for (int i = 0; i < 253; i++) begin
      send(2'd0, 1'b1);
      tick();
    end
    chk("s7_pass_255", pass_cnt, 255);
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 1'b1);
      tick();
    end
    chk("s7_pass_sat", pass_cnt, 255);
    chk("s7_beat0", beat_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spec_seq_checker.md
SPEC_SEQ_CHECKER -- requirements
Module: spec_seq_checker

Interface
REQ-001 SHALL have parameter NUM_CODES, default 3, number of legal codes in the enum sequence (industry=0, medical=1, education=2).
REQ-002 SHALL have parameter CODE_W, default 2, width of code field; NUM_CODES <= 2**CODE_W.
REQ-003 SHALL have parameter CNT_W, default 8, width of pass/beat counters.
REQ-004 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, code beat valid.
REQ-007 SHALL have port in_ready, output, 1, checker can accept a beat.
REQ-008 SHALL have port in_code, input, CODE_W, received enum code.
REQ-009 SHALL have port in_last, input, 1, beat closes current sequence.
REQ-010 SHALL have port clr, input, 1, synchronous clear of sticky error.
REQ-011 SHALL have port expect_code, output, CODE_W, next code the checker will accept.
REQ-012 SHALL have port seq_done, output, 1, one-cycle pulse on clean sequence completion.
REQ-013 SHALL have port err, output, 1, sticky mismatch flag.
REQ-014 SHALL have port err_code, output, CODE_W, offending code captured at error.
REQ-015 SHALL have port pass_cnt, output, CNT_W, count of clean sequences, saturating.
REQ-016 SHALL have port beat_cnt, output, CNT_W, beats accepted in current sequence, saturating.

Function
REQ-017 SHALL accept a beat only when in_valid and in_ready are both high on a rising clk edge.
REQ-018 SHALL implement FSM states IDLE, CHECK, DONE, ERROR.
REQ-019 SHALL drive in_ready high in IDLE and CHECK, low in DONE and ERROR.
REQ-020 SHALL hold expect_code at 0 (first) in IDLE; first accepted beat must equal 0.
REQ-021 SHALL, after each correct beat, set expect_code to expect_code+1, wrapping NUM_CODES-1 to 0 (next with wrap).
REQ-022 SHALL treat in_code >= NUM_CODES or in_code != expect_code as mismatch: go to ERROR, set err, capture err_code, same edge.
REQ-023 SHALL transition IDLE->CHECK on correct beat without in_last; IDLE/CHECK->DONE on correct beat with in_last.
REQ-024 SHALL, in DONE, pulse seq_done for exactly one cycle, increment pass_cnt (saturate at all-ones), clear beat_cnt and expect_code, then return to IDLE next cycle.
REQ-025 SHALL increment beat_cnt on every accepted correct beat, saturating; beat_cnt holds its value in ERROR.
REQ-026 SHALL remain in ERROR until clr; clr in ERROR clears err, err_code, beat_cnt, expect_code, goes to IDLE; pass_cnt retained.
REQ-027 SHALL ignore clr outside ERROR.
REQ-028 SHALL give mismatch precedence over in_last on the same beat (ERROR, no seq_done, no pass_cnt increment).
REQ-029 SHALL have zero-cycle combinational path from state to in_ready only; no combinational in_valid->in_ready path.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force state IDLE, expect_code 0, seq_done 0, err 0, err_code 0, pass_cnt 0, beat_cnt 0.
REQ-031 SHALL, on reset mid-sequence, discard the partial sequence; first beat after release is checked against 0.
REQ-032 SHALL drive in_ready high in the first cycle after rst_n deasserts.

Configuration
REQ-033 SHALL, with macro SPEC_SEQ_TRACE_EN defined, print simulation line "state=<name>" (industry/medical/education, else "illegal") per accepted beat and "spe=<name>" on err set; without it, no display statements compile and RTL behaviour is identical.

Verification
REQ-034 SHALL cover: codes 0,1,2 with in_last on 2 -> seq_done pulse one cycle after last beat, pass_cnt=1, expect_code back to 0.
REQ-035 SHALL cover: codes 0,1,2,0,1 with in_last on 1 (wrap) -> seq_done, pass_cnt increments, beat_cnt reaches 5 before clearing.
REQ-036 SHALL cover: codes 0,2 -> err=1, err_code=2, in_ready=0, beat_cnt=1; clr -> err=0, in_ready=1, pass_cnt unchanged.
REQ-037 SHALL cover: illegal code 3 as first beat with in_last -> ERROR, err_code=3, no seq_done.
REQ-038 SHALL cover: rst_n pulsed low after codes 0,1 -> all outputs zero immediately; next sequence 0,1,2 with last passes.
REQ-039 SHALL cover: 256 clean sequences with CNT_W=8 -> pass_cnt saturates at 255.
